// File: rtl/sub_arb_pkg.sv
// Shared types and default sizing for the subtractor arbiter slice.
package sub_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF   = 8;
    localparam int unsigned ID_W_DEF    = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin grant: first set request at or above i_ptr, wrapping at NUM_REQ.
module rr_arb
    import sub_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ID_W    = ID_W_DEF
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx
);

    int unsigned       w_pos;
    logic [ID_W-1:0]   w_cand;
    logic              w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_pos   = 0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_pos = 32'(i_ptr) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_cand = ID_W'(w_pos);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = i_en;
            end
        end
    end

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin sharing of one subtractor with a single-entry registered response.
// Optional SUB_ARB_SAT_EN: clamp rsp_diff to zero on borrow.
module sub_arbiter
    import sub_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned ID_W    = ID_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_diff,
    output logic                     rsp_borrow,
    output logic [ID_W-1:0]          rsp_id
);

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic [ID_W-1:0]    r_id;

    logic               w_can_accept;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_diff;
    logic [ID_W-1:0]    w_ptr_nxt;

    // rst_n gates the grant so nothing is offered while reset is held
    assign w_can_accept = rst_n && ((r_state == ST_EMPTY) || rsp_ready);

    rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_can_accept),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign req_ready = w_grant;
    assign w_xfer    = |w_grant;

    assign w_a   = req_a[w_idx*WIDTH +: WIDTH];
    assign w_b   = req_b[w_idx*WIDTH +: WIDTH];
    assign w_sub = {1'b0, w_a} - {1'b0, w_b};

`ifdef SUB_ARB_SAT_EN
    assign w_diff = w_sub[WIDTH] ? '0 : w_sub[WIDTH-1:0];
`else
    assign w_diff = w_sub[WIDTH-1:0];
`endif

    assign w_ptr_nxt = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_ptr    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_id     <= '0;
        end else begin
            if (w_xfer) begin
                r_state  <= ST_FULL;
                r_ptr    <= w_ptr_nxt;
                r_diff   <= w_diff;
                r_borrow <= w_sub[WIDTH];
                r_id     <= w_idx;
            end else if (rsp_ready) begin
                r_state <= ST_EMPTY;
            end
        end
    end

    assign rsp_valid  = (r_state == ST_FULL);
    assign rsp_diff   = r_diff;
    assign rsp_borrow = r_borrow;
    assign rsp_id     = r_id;

endmodule

// File: tb/tb_sub_arbiter.sv
// Directed scoreboard bench for sub_arbiter; honours SUB_ARB_SAT_EN for expected values.
module tb_sub_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int IW = 2;

`ifdef SUB_ARB_SAT_EN
    localparam logic [7:0] UF_03_08 = 8'h00;
    localparam logic [7:0] UF_09_0A = 8'h00;
    localparam logic [7:0] UF_00_FF = 8'h00;
    localparam logic [7:0] UF_01_02 = 8'h00;
`else
    localparam logic [7:0] UF_03_08 = 8'hFB;
    localparam logic [7:0] UF_09_0A = 8'hFF;
    localparam logic [7:0] UF_00_FF = 8'h01;
    localparam logic [7:0] UF_01_02 = 8'hFF;
`endif

    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
        logic [1:0] id;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR*W-1:0]   req_a;
    logic [NR*W-1:0]   req_b;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_diff;
    logic              rsp_borrow;
    logic [IW-1:0]     rsp_id;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    sub_arbiter #(
        .NUM_REQ (NR),
        .WIDTH   (W),
        .ID_W    (IW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_diff   (rsp_diff),
        .rsp_borrow (rsp_borrow),
        .rsp_id     (rsp_id)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted response is popped against the scoreboard
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got diff=%h borrow=%b id=%0d required no response",
                         rsp_diff, rsp_borrow, rsp_id);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_diff, rsp_borrow, rsp_id} !== mon_e) begin
                    errors++;
                    $display("FAIL rsp got diff=%h borrow=%b id=%0d required diff=%h borrow=%b id=%0d",
                             rsp_diff, rsp_borrow, rsp_id, mon_e.diff, mon_e.borrow, mon_e.id);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic push(input logic [7:0] d, input logic bo, input logic [1:0] id);
        exp_q.push_back(rsp_t'{d, bo, id});
    endtask

    // Drive valids for one cycle and check the combinational grant mid-cycle
    task automatic grant_cycle(input logic [3:0] valid, input logic [3:0] exp_ready);
        req_valid = valid;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got running required finished");
        $fatal(1, "timeout");
    end

    logic [7:0] rr_diff [4];

    initial begin
        rr_diff = '{8'h0C, 8'h1D, 8'h2E, 8'h3F};
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_diff", 32'(rsp_diff), 0);
        chk("rst_rsp_borrow", 32'(rsp_borrow), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;

        // single request and underflow
        set_op(0, 8'h0B, 8'h08); push(8'h03, 1'b0, 2'd0);
        grant_cycle(4'b0001, 4'b0001);
        set_op(1, 8'h03, 8'h08); push(UF_03_08, 1'b1, 2'd1);
        grant_cycle(4'b0010, 4'b0010);
        set_op(3, 8'h10, 8'h01); push(8'h0F, 1'b0, 2'd3);
        grant_cycle(4'b1000, 4'b1000);

        // round robin, all valid, one response per cycle
        set_op(0, 8'h10, 8'h04);
        set_op(1, 8'h20, 8'h03);
        set_op(2, 8'h30, 8'h02);
        set_op(3, 8'h40, 8'h01);
        for (int k = 0; k < 8; k++) begin
            push(rr_diff[k % 4], 1'b0, 2'(k % 4));
            grant_cycle(4'hF, 4'(1 << (k % 4)));
        end
        grant_cycle(4'b0000, 4'b0000);

        // backpressure
        set_op(0, 8'h55, 8'h15); push(8'h40, 1'b0, 2'd0);
        grant_cycle(4'b0001, 4'b0001);
        rsp_ready = 1'b0;
        set_op(1, 8'h09, 8'h0A);
        set_op(2, 8'h80, 8'h7F);
        req_valid = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_diff", 32'(rsp_diff), 32'h40);
            chk("bp_rsp_id", 32'(rsp_id), 0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        push(UF_09_0A, 1'b1, 2'd1);
        grant_cycle(4'b0110, 4'b0010);
        push(8'h01, 1'b0, 2'd2);
        grant_cycle(4'b0100, 4'b0100);
        grant_cycle(4'b0000, 4'b0000);

        // sparse requests with ptr at 1
        set_op(0, 8'hFF, 8'h00); push(8'hFF, 1'b0, 2'd0);
        grant_cycle(4'b0001, 4'b0001);
        set_op(0, 8'h07, 8'h07);
        set_op(2, 8'h00, 8'hFF); push(UF_00_FF, 1'b1, 2'd2);
        grant_cycle(4'b0101, 4'b0100);
        push(8'h00, 1'b0, 2'd0);
        grant_cycle(4'b0001, 4'b0001);
        grant_cycle(4'b0000, 4'b0000);

        // reset while FULL: held response is discarded
        rsp_ready = 1'b0;
        set_op(2, 8'hAA, 8'h55);
        grant_cycle(4'b0100, 4'b0100);
        req_valid = 4'hF;
        @(negedge clk);
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 1);
        chk("pre_rst_rsp_diff", 32'(rsp_diff), 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("async_rst_rsp_diff", 32'(rsp_diff), 0);
        chk("async_rst_rsp_id", 32'(rsp_id), 0);
        chk("async_rst_req_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        set_op(1, 8'h64, 8'h32); push(8'h32, 1'b0, 2'd1);
        set_op(3, 8'h01, 8'h02);
        grant_cycle(4'b1010, 4'b0010);
        push(UF_01_02, 1'b1, 2'd3);
        grant_cycle(4'b1000, 4'b1000);
        grant_cycle(4'b0000, 4'b0000);
        grant_cycle(4'b0000, 4'b0000);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_arbiter.md
# sub_arbiter

Round-robin arbiter and sequencer sharing one 8-bit subtractor among several requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, performs a - b through the shared subtractor, and returns the difference, borrow and requester ID through a single-entry registered response port with backpressure. It sits between the requesting units and the subtractor datapath, so the subtractor does not have to be duplicated per client.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- WIDTH, 8: operand/result width
- ID_W, 2: requester ID width, equals clog2(NUM_REQ)
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*WIDTH  minuends; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  subtrahends, same packing as req_a
- req_ready  out  NUM_REQ  one-hot grant; a request transfers when req_valid[i] and req_ready[i] are both high
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_diff  out  WIDTH  a - b modulo 2^WIDTH
- rsp_borrow  out  1  high when a < b (unsigned)
- rsp_id  out  ID_W  index of the served requester

## Operation
- State machine: EMPTY (no held response) and FULL (response held).
- Can-accept condition: state is EMPTY, or state is FULL and rsp_ready is high.
- Grant:
  - When the can-accept condition holds, exactly one req_ready bit is raised. It goes to the first requester with req_valid high, searching from index ptr upward and wrapping at NUM_REQ.
  - Otherwise req_ready is all zero.
  - req_ready is combinational from req_valid, ptr, state and rsp_ready. req_ready never depends on the requester's own data.
- Priority pointer ptr:
  - Resets to 0.
  - On every transfer, ptr becomes the granted index + 1, modulo NUM_REQ.
  - With no transfer, ptr holds.
- Arithmetic: the WIDTH+1-bit result {borrow, diff} = {1'b0, a} - {1'b0, b}; borrow is the MSB.
- On a transfer:
  - rsp_diff, rsp_borrow and rsp_id register the result of the granted requester.
  - The state becomes FULL.
- On rsp_valid and rsp_ready with no new transfer, the state becomes EMPTY.
- With a response accepted and a new transfer in the same cycle, the state stays FULL and the output register is overwritten. This sustains one operation per cycle.
- Requesters must hold a and b stable while valid is high and not granted. The block does not check this.
- With no requester valid, no grant is made and ptr holds.

## Timing
- Latency is one cycle: a transfer at edge k makes rsp_valid high after edge k.
- Throughput is one response per cycle when rsp_ready is held high.
- Backpressure: with FULL state and rsp_ready low, all req_ready bits are low and the response outputs are stable.
- Reset values:
  - rsp_valid = 0, rsp_diff = 0, rsp_borrow = 0, rsp_id = 0
  - ptr = 0, state EMPTY
  - req_ready = 0 while rst_n is low
- Reset mid-operation: an asserted rst_n discards the held response immediately, asynchronously. In-flight grants are lost, and requesters must re-present them.
- Fairness: a continuously valid requester is granted within NUM_REQ transfers.

## Configuration
- SUB_ARB_SAT_EN defined:
  - When borrow is 1, rsp_diff is forced to 0 (saturating unsigned subtract).
  - rsp_borrow still reports the borrow.
- SUB_ARB_SAT_EN undefined: rsp_diff is the wrap-around result modulo 2^WIDTH.

## Structure
- Shared package sub_arb_pkg holds:
  - the state encoding type (EMPTY, FULL)
  - the default constants for NUM_REQ, WIDTH and ID_W
- Sub-module rr_arb:
  - pure round-robin grant logic
  - inputs: request vector, ptr, enable
  - outputs: one-hot grant and the encoded index
- The subtractor stays inline in sub_arbiter; it is a single WIDTH+1-bit subtraction.

## Test plan
- Single request: req 0 with a=0x0B, b=0x08, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_diff=0x03, rsp_borrow=0, rsp_id=0.
- Underflow: req 1 with a=0x03, b=0x08 -> rsp_diff=0xFB, rsp_borrow=1. With SUB_ARB_SAT_EN -> rsp_diff=0x00, rsp_borrow=1.
- Round robin: all 4 requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,... with one response per cycle and rsp_id matching.
- Backpressure: rsp_ready=0 after the first response -> req_ready stays all zero and the outputs stay stable. When rsp_ready goes high, the next grant occurs in the same cycle and the response is replaced on the next edge.
- Reset mid-stream: drop rst_n while FULL -> rsp_valid=0 immediately. After release, the first grant goes to the lowest valid index (ptr=0).
- Sparse requests: only req 2 and req 0 valid, with ptr=1 -> req 2 is granted first, then req 0.
